ikaopll_timinggen_param: RTL
============================

Name: ikaopll_timinggen_param

Overview:
- Parametrised successor of the OPLL timing generator.
- Divides phiM into phi1 clock enables and runs a slot sequencer with configurable subcycles × groups.
- Emits slot indices, frame strobes, modulator/carrier select, rhythm-slot flags and delayed group bits.
- Sits between the chip clock/reset front-end and the operator/envelope pipelines. Unlike the fixed 18-slot version, the rhythm mode is latched at a frame boundary.

Parameters:
- CLK_DIV, 4: phiM enables per phi1 period; must be even, ≥2.
- SUB_CYCLES, 6: slots per group, 2..8.
- GROUPS, 3: groups per frame, 1..8; NUM_SLOTS = SUB_CYCLES*GROUPS.
- MOD_MASK, 6'b100011: bit s=1 means subcycle s is a modulator slot; width SUB_CYCLES.
- RHYTHM_GRP, 2: group whose slots become rhythm slots in rhythm mode.
- DLY_DEPTH, 2: phi1 delay applied to o_GRP_DLY, 1..4.

Ports:
- i_EMUCLK, in, 1: emulator master clock, the only clock.
- i_IC, in, 1: reset; synchronous, active-high, sampled on every i_EMUCLK rising edge.
- i_phiM_PCEN_n, in, 1: phiM clock enable, active-low.
- i_RHYTHM_EN, in, 1: requested rhythm mode.
- o_phi1_PCEN_n, out, 1: phi1 positive-edge enable, active-low.
- o_phi1_NCEN_n, out, 1: phi1 negative-edge enable, active-low.
- o_DAC_EN, out, 1: DAC strobe, high for one phiM enable per phi1 period.
- o_SUB, out, 3: current subcycle.
- o_GRP, out, 3: current group.
- o_SLOT, out, 6: flat slot index, GRP*SUB_CYCLES+SUB.
- o_FRAME_START, out, 1: high while o_SLOT==0.
- o_FRAME_END, out, 1: high while o_SLOT==NUM_SLOTS-1.
- o_MnC_SEL, out, 1: MOD_MASK[o_SUB].
- o_RHYTHM_SLOT, out, 1: latched rhythm mode AND o_GRP==RHYTHM_GRP.
- o_RHYTHM_ACT, out, 1: latched rhythm mode.
- o_GRP_DLY, out, 3: o_GRP delayed DLY_DEPTH phi1 periods.
- o_FRAME_CNT, out, 16: frame counter (optional feature).

Behaviour:
- Reset (i_IC high at an edge), regardless of i_phiM_PCEN_n:
  - Phase counter p=0; SUB=0, GRP=0; delay line, rhythm latch and frame counter cleared.
  - Registered outputs 0. o_phi1_PCEN_n/o_phi1_NCEN_n forced 1, o_DAC_EN forced 0 while i_IC high.
  - Combinational outputs follow the cleared state: o_FRAME_START=1, o_MnC_SEL=MOD_MASK[0].
- Phase:
  - On each i_phiM_PCEN_n=0 cycle with i_IC low, p advances, wrapping at CLK_DIV-1.
  - o_phi1_PCEN_n = ~(p==CLK_DIV/2-1 & ~i_phiM_PCEN_n).
  - o_phi1_NCEN_n = ~(p==CLK_DIV-1 & ~i_phiM_PCEN_n).
  - o_DAC_EN = (p==0 & ~i_phiM_PCEN_n).
  - The first NCEN after reset release occurs on the CLK_DIV-th phiM enable.
- Sequencer, on NCEN:
  - SUB increments and wraps to 0 after SUB_CYCLES-1.
  - On that wrap, GRP increments and wraps to 0 after GRP=GROUPS-1.
  - Slot outputs are combinational from the counters; the index advances 1 per phi1.
- Rhythm latch:
  - i_RHYTHM_EN is sampled only on the NCEN where o_FRAME_END=1; it takes effect from slot 0 of the next frame.
  - Mid-frame toggles of i_RHYTHM_EN are ignored until then.
- Delay line: DLY_DEPTH-stage shift of o_GRP on NCEN; o_GRP_DLY is the last stage.
- Reset mid-frame: counters restart at slot 0 on the next edge; no partial frame counted.
- Parameter checks: CLK_DIV odd, or SUB_CYCLES*GROUPS>64, must fail elaboration ($error in generate).

Optional Feature:
- Macro: IKAOPLL_TIMINGGEN_FRAME_CNT_EN.
- Defined: o_FRAME_CNT increments on the NCEN where o_FRAME_END=1; wraps 16'hFFFF→0; cleared by i_IC.
- Undefined: o_FRAME_CNT tied to 16'd0 and no counter flops are built.

Test Plan:
- Defaults, phiM enable every cycle, release i_IC:
  - First o_phi1_PCEN_n low on the 2nd enable and first NCEN on the 4th; thereafter PCEN and NCEN each repeat every 4 cycles.
  - o_SLOT sequence 0..17 then 0.
- Defaults, continuous run:
  - o_MnC_SEL=1 exactly at SUB∈{0,1,5}.
  - o_FRAME_START and o_FRAME_END each pulse once per 18 phi1 periods.
- Raise i_RHYTHM_EN at slot 7:
  - o_RHYTHM_ACT stays 0 until o_SLOT returns to 0, then rises.
  - o_RHYTHM_SLOT=1 only at slots 12..17.
- Assert i_IC for 1 cycle at slot 11:
  - Next cycle o_SLOT=0, o_GRP_DLY=0, enables high.
  - Sequence then resumes from 0 after 4 phiM enables.
- SUB_CYCLES=4, GROUPS=9, CLK_DIV=2:
  - Elaboration fails, because GROUPS=9 exceeds its 1..8 range.
  - With GROUPS=8, o_SLOT wraps 31→0 and NCEN occurs every 2 enables.
- Macro defined, defaults, 65536 frames:
  - o_FRAME_CNT reaches 16'hFFFF, then 0.
  - Macro undefined: o_FRAME_CNT stays 0.

Source files
------------

// File: rtl/ikaopll_timinggen_param_if.sv
// Signal bundle between the OPLL timing generator and its consumers.
// The slave modport is the generator side; the master modport drives the enables and rhythm request.
interface ikaopll_timinggen_param_if;
  logic        i_phiM_PCEN_n;
  logic        i_RHYTHM_EN;
  logic        o_phi1_PCEN_n;
  logic        o_phi1_NCEN_n;
  logic        o_DAC_EN;
  logic [2:0]  o_SUB;
  logic [2:0]  o_GRP;
  logic [5:0]  o_SLOT;
  logic        o_FRAME_START;
  logic        o_FRAME_END;
  logic        o_MnC_SEL;
  logic        o_RHYTHM_SLOT;
  logic        o_RHYTHM_ACT;
  logic [2:0]  o_GRP_DLY;
  logic [15:0] o_FRAME_CNT;

  modport master (
    output i_phiM_PCEN_n, i_RHYTHM_EN,
    input  o_phi1_PCEN_n, o_phi1_NCEN_n, o_DAC_EN, o_SUB, o_GRP, o_SLOT,
           o_FRAME_START, o_FRAME_END, o_MnC_SEL, o_RHYTHM_SLOT, o_RHYTHM_ACT,
           o_GRP_DLY, o_FRAME_CNT
  );

  modport slave (
    input  i_phiM_PCEN_n, i_RHYTHM_EN,
    output o_phi1_PCEN_n, o_phi1_NCEN_n, o_DAC_EN, o_SUB, o_GRP, o_SLOT,
           o_FRAME_START, o_FRAME_END, o_MnC_SEL, o_RHYTHM_SLOT, o_RHYTHM_ACT,
           o_GRP_DLY, o_FRAME_CNT
  );
endinterface

// File: rtl/ikaopll_timinggen_param.sv
// Parametrised OPLL timing generator: phiM -> phi1 enables, subcycle x group slot sequencer.
// Optional frame counter enabled by defining IKAOPLL_TIMINGGEN_FRAME_CNT_EN.
module ikaopll_timinggen_param #(
  parameter int                    CLK_DIV    = 4,
  parameter int                    SUB_CYCLES = 6,
  parameter int                    GROUPS     = 3,
  parameter logic [SUB_CYCLES-1:0] MOD_MASK   = 6'b100011,
  parameter int                    RHYTHM_GRP = 2,
  parameter int                    DLY_DEPTH  = 2
) (
  input logic                      i_EMUCLK,
  input logic                      i_IC,
  ikaopll_timinggen_param_if.slave bus
);

  localparam int NUM_SLOTS = SUB_CYCLES * GROUPS;
  localparam int PW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [7:0] MASK8 = 8'(MOD_MASK);

  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_clk_div
    $error("CLK_DIV must be even and at least 2");
  end
  if (SUB_CYCLES < 2 || SUB_CYCLES > 8) begin : g_bad_sub
    $error("SUB_CYCLES must be in 2..8");
  end
  if (GROUPS < 1 || GROUPS > 8) begin : g_bad_groups
    $error("GROUPS must be in 1..8");
  end
  if (NUM_SLOTS > 64) begin : g_bad_slots
    $error("SUB_CYCLES*GROUPS must not exceed 64");
  end
  if (DLY_DEPTH < 1 || DLY_DEPTH > 4) begin : g_bad_dly
    $error("DLY_DEPTH must be in 1..4");
  end

  logic [PW-1:0] p_q;
  logic [2:0]    sub_q;
  logic [2:0]    grp_q;
  logic          rhythm_q;
  logic [2:0]    dly_q [DLY_DEPTH];

  logic       phim_en;
  logic       p_last;
  logic       p_half;
  logic       ncen;
  logic       sub_last;
  logic       grp_last;
  logic [5:0] slot;
  logic       frame_end;

  assign phim_en   = ~bus.i_phiM_PCEN_n & ~i_IC;
  assign p_last    = (p_q == PW'(CLK_DIV - 1));
  assign p_half    = (p_q == PW'(CLK_DIV / 2 - 1));
  assign ncen      = phim_en & p_last;
  assign sub_last  = (sub_q == 3'(SUB_CYCLES - 1));
  assign grp_last  = (grp_q == 3'(GROUPS - 1));
  assign slot      = 6'(grp_q) * 6'(SUB_CYCLES) + 6'(sub_q);
  assign frame_end = (slot == 6'(NUM_SLOTS - 1));

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_EMUCLK) begin
    if (i_IC) begin
      p_q <= '0;
    end else if (phim_en) begin
      p_q <= p_last ? '0 : p_q + 1'b1;
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_IC) begin
      sub_q <= '0;
      grp_q <= '0;
    end else if (ncen) begin
      if (sub_last) begin
        sub_q <= '0;
        grp_q <= grp_last ? 3'd0 : grp_q + 3'd1;
      end else begin
        sub_q <= sub_q + 3'd1;
      end
    end
  end

  // Rhythm request only lands on the last slot so a frame never changes mode midway.
  always_ff @(posedge i_EMUCLK) begin
    if (i_IC) begin
      rhythm_q <= 1'b0;
    end else if (ncen & frame_end) begin
      rhythm_q <= bus.i_RHYTHM_EN;
    end
  end

  // NOTE: the delay line is a tiny shift register, so it is cleared on reset
  // to keep o_GRP_DLY defined; larger storage arrays would not be reset.
  always_ff @(posedge i_EMUCLK) begin
    if (i_IC) begin
      for (int i = 0; i < DLY_DEPTH; i++) dly_q[i] <= '0;
    end else if (ncen) begin
      dly_q[0] <= grp_q;
      for (int i = 1; i < DLY_DEPTH; i++) dly_q[i] <= dly_q[i-1];
    end
  end

`ifdef IKAOPLL_TIMINGGEN_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge i_EMUCLK) begin
    if (i_IC) begin
      frame_cnt_q <= '0;
    end else if (ncen & frame_end) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign bus.o_FRAME_CNT = frame_cnt_q;
`else
  assign bus.o_FRAME_CNT = 16'd0;
`endif

  assign bus.o_phi1_PCEN_n = ~(phim_en & p_half);
  assign bus.o_phi1_NCEN_n = ~ncen;
  assign bus.o_DAC_EN      = phim_en & (p_q == '0);
  assign bus.o_SUB         = sub_q;
  assign bus.o_GRP         = grp_q;
  assign bus.o_SLOT        = slot;
  assign bus.o_FRAME_START = (slot == 6'd0);
  assign bus.o_FRAME_END   = frame_end;
  assign bus.o_MnC_SEL     = MASK8[sub_q];
  assign bus.o_RHYTHM_ACT  = rhythm_q;
  assign bus.o_RHYTHM_SLOT = rhythm_q & (grp_q == 3'(RHYTHM_GRP));
  assign bus.o_GRP_DLY     = dly_q[DLY_DEPTH-1];

endmodule
